// File: rtl/fwrisc_shadow_stack_checker_if.sv
// fwrisc_shadow_stack_checker_if: decode/writeback observation and error/status signals of the shadow stack checker
interface fwrisc_shadow_stack_checker_if #(
    parameter int DEPTH = 16
);
    localparam int DEPTH_W = $clog2(DEPTH);
    logic             decode_valid;
    logic [4:0]       op_type;
    logic [5:0]       op;
    logic [5:0]       rs1;
    logic [5:0]       rd;
    logic             link_valid;
    logic [31:0]      link_data;
    logic             jump_valid;
    logic [31:0]      jump_target;
    logic             ld_valid;
    logic [31:0]      ld_data;
    logic             err_valid;
    logic [1:0]       err_kind;
    logic [31:0]      err_exp;
    logic [31:0]      err_act;
    logic [DEPTH_W:0] depth;
    logic             overflow;
    modport master (
        output decode_valid, op_type, op, rs1, rd, link_valid, link_data,
               jump_valid, jump_target, ld_valid, ld_data,
        input  err_valid, err_kind, err_exp, err_act, depth, overflow
    );
    modport slave (
        input  decode_valid, op_type, op, rs1, rd, link_valid, link_data,
               jump_valid, jump_target, ld_valid, ld_data,
        output err_valid, err_kind, err_exp, err_act, depth, overflow
    );
endinterface

// File: rtl/fwrisc_shadow_stack_checker.sv
// fwrisc_shadow_stack_checker: shadow stack of return addresses checked on returns and link reloads.
// Define FWRISC_SHADOW_STACK_TIMEOUT_EN to abandon a wait state after 15 idle cycles with a TIMEOUT error.
module fwrisc_shadow_stack_checker #(
    parameter int DEPTH = 16
) (
    input logic clock,
    input logic reset,
    fwrisc_shadow_stack_checker_if.slave bus
);
    localparam int DEPTH_W = $clog2(DEPTH);
    localparam logic [DEPTH_W:0] FULL = DEPTH[DEPTH_W:0];
    localparam logic [4:0] OP_TYPE_LDST = 5'd2;
    localparam logic [4:0] OP_TYPE_JUMP = 5'd4;
    localparam logic [5:0] OP_LW = 6'd2;
    localparam logic [1:0] RET_MISMATCH = 2'd0;
    localparam logic [1:0] LOAD_MISMATCH = 2'd1;
    localparam logic [1:0] UNDERFLOW = 2'd2;
    typedef enum logic [1:0] {IDLE, CALL_WAIT, RET_WAIT, LOAD_WAIT} state_t;
    state_t state, state_nx;
    logic [31:0] stk [DEPTH];
    logic [DEPTH_W-1:0] ptr;
    logic [DEPTH_W:0] depth;
    logic overflow, err_valid, err_nx, push, pop;
    logic [1:0] err_kind, kind_nx;
    logic [31:0] err_exp, err_act, exp_nx, act_nx, top;
    logic rd_link, rs1_link;
    assign top = stk[ptr - 1'b1];
    assign rd_link = bus.rd == 6'd1 || bus.rd == 6'd5;
    assign rs1_link = bus.rs1 == 6'd1 || bus.rs1 == 6'd5;
`ifdef FWRISC_SHADOW_STACK_TIMEOUT_EN
    logic [3:0] tmo;
    always_ff @(posedge clock)
        tmo <= (reset || state == IDLE) ? 4'd0 : tmo + 4'd1;
`endif
    always_comb begin
        state_nx = state;
        push = 1'b0;
        pop = 1'b0;
        err_nx = 1'b0;
        kind_nx = err_kind;
        exp_nx = err_exp;
        act_nx = err_act;
        case (state)
            IDLE: if (bus.decode_valid) begin
                if (bus.op_type == OP_TYPE_JUMP)
                    state_nx = rd_link ? CALL_WAIT : (bus.rd == 6'd0 && rs1_link) ? RET_WAIT : IDLE;
                else if (bus.op_type == OP_TYPE_LDST && bus.op == OP_LW && rd_link)
                    state_nx = LOAD_WAIT;
            end
            CALL_WAIT: if (bus.link_valid) begin
                push = 1'b1;
                state_nx = IDLE;
            end
            RET_WAIT: if (bus.jump_valid) begin
                state_nx = IDLE;
                pop = depth != '0;
                err_nx = depth == '0 || bus.jump_target != top;
                kind_nx = depth == '0 ? UNDERFLOW : RET_MISMATCH;
                exp_nx = depth == '0 ? 32'd0 : top;
                act_nx = bus.jump_target;
            end
            LOAD_WAIT: if (bus.ld_valid) begin
                state_nx = IDLE;
                err_nx = depth != '0 && bus.ld_data != top;
                kind_nx = LOAD_MISMATCH;
                exp_nx = top;
                act_nx = bus.ld_data;
            end
            default: state_nx = IDLE;
        endcase
`ifdef FWRISC_SHADOW_STACK_TIMEOUT_EN
        // state_nx still equals a wait state only when its strobe did not arrive
        if (state != IDLE && state_nx == state && tmo == 4'd15) begin
            state_nx = IDLE;
            err_nx = 1'b1;
            kind_nx = 2'd3;
            exp_nx = 32'd0;
            act_nx = 32'd0;
        end
`endif
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            ptr <= '0;
            depth <= '0;
            overflow <= 1'b0;
            err_valid <= 1'b0;
            err_kind <= 2'd0;
            err_exp <= 32'd0;
            err_act <= 32'd0;
        end else begin
            state <= state_nx;
            err_valid <= err_nx;
            if (err_nx) begin
                err_kind <= kind_nx;
                err_exp <= exp_nx;
                err_act <= act_nx;
            end
            if (push) begin
                ptr <= ptr + 1'b1;
                depth <= depth == FULL ? depth : depth + 1'b1;
                overflow <= overflow | (depth == FULL);
            end else if (pop) begin
                ptr <= ptr - 1'b1;
                depth <= depth - 1'b1;
            end
        end
    end
    always_ff @(posedge clock)
        if (!reset && push) stk[ptr] <= bus.link_data;
    assign bus.err_valid = err_valid;
    assign bus.err_kind = err_kind;
    assign bus.err_exp = err_exp;
    assign bus.err_act = err_act;
    assign bus.depth = depth;
    assign bus.overflow = overflow;
endmodule

// File: tb/tb_fwrisc_shadow_stack_checker.sv
// tb_fwrisc_shadow_stack_checker: directed scoreboard bench; expected errors are queued and matched by a monitor
module tb_fwrisc_shadow_stack_checker;
    localparam logic [4:0] T_JUMP = 5'd4;
    localparam logic [4:0] T_LDST = 5'd2;
    localparam logic [5:0] LW = 6'd2;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int total = 0;
    int bad = 0;
    logic [65:0] expq [$];
    fwrisc_shadow_stack_checker_if #(.DEPTH(16)) bus ();
    fwrisc_shadow_stack_checker #(.DEPTH(16)) dut (.clock(clock), .reset(reset), .bus(bus));
    always #5 clock = ~clock;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask
    always @(negedge clock) begin
        if (!reset && bus.err_valid) begin
            if (expq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_err: kind=%0d exp=0x%0h act=0x%0h", bus.err_kind, bus.err_exp, bus.err_act);
            end else begin
                logic [65:0] e;
                e = expq.pop_front();
                chk("err_kind", {30'd0, bus.err_kind}, {30'd0, e[65:64]});
                chk("err_exp", bus.err_exp, e[63:32]);
                chk("err_act", bus.err_act, e[31:0]);
            end
        end
    end
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask
    task automatic dec(input logic [4:0] t, input logic [5:0] o, input logic [5:0] s1, input logic [5:0] d);
        bus.decode_valid = 1'b1;
        bus.op_type = t;
        bus.op = o;
        bus.rs1 = s1;
        bus.rd = d;
        cyc();
        bus.decode_valid = 1'b0;
    endtask
    task automatic call(input logic [31:0] lnk);
        dec(T_JUMP, 6'd0, 6'd0, 6'd1);
        bus.link_valid = 1'b1;
        bus.link_data = lnk;
        cyc();
        bus.link_valid = 1'b0;
    endtask
    task automatic ret(input logic [31:0] tgt, input bit e, input logic [1:0] k, input logic [31:0] x);
        dec(T_JUMP, 6'd0, 6'd1, 6'd0);
        if (e) expq.push_back({k, x, tgt});
        bus.jump_valid = 1'b1;
        bus.jump_target = tgt;
        cyc();
        bus.jump_valid = 1'b0;
        cyc();
    endtask
    task automatic ld(input logic [31:0] dat, input bit e, input logic [31:0] x);
        dec(T_LDST, LW, 6'd2, 6'd1);
        if (e) expq.push_back({2'd1, x, dat});
        bus.ld_valid = 1'b1;
        bus.ld_data = dat;
        cyc();
        bus.ld_valid = 1'b0;
        cyc();
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
    initial begin
        bus.decode_valid = 0; bus.op_type = 0; bus.op = 0; bus.rs1 = 0; bus.rd = 0;
        bus.link_valid = 0; bus.link_data = 0; bus.jump_valid = 0; bus.jump_target = 0;
        bus.ld_valid = 0; bus.ld_data = 0;
        repeat (3) cyc();
        reset = 1'b0;
        cyc();
        chk("rst_err_valid", {31'd0, bus.err_valid}, 32'd0);
        chk("rst_err_kind", {30'd0, bus.err_kind}, 32'd0);
        chk("rst_err_exp", bus.err_exp, 32'd0);
        chk("rst_err_act", bus.err_act, 32'd0);
        chk("rst_depth", {27'd0, bus.depth}, 32'd0);
        chk("rst_overflow", {31'd0, bus.overflow}, 32'd0);
        call(32'h104);
        chk("call_depth", {27'd0, bus.depth}, 32'd1);
        ret(32'h104, 0, 2'd0, 32'd0);
        chk("ret_ok_depth", {27'd0, bus.depth}, 32'd0);
        call(32'h104);
        ret(32'h108, 1, 2'd0, 32'h104);
        chk("ret_bad_depth", {27'd0, bus.depth}, 32'd0);
        ret(32'h200, 1, 2'd2, 32'd0);
        chk("underflow_depth", {27'd0, bus.depth}, 32'd0);
        call(32'h100);
        ld(32'h100, 0, 32'd0);
        ld(32'hDEAD, 1, 32'h100);
        chk("load_depth", {27'd0, bus.depth}, 32'd1);
        ret(32'h100, 0, 2'd0, 32'd0);
        for (int i = 0; i <= 16; i++) call(32'h1000 + 4 * i);
        chk("full_depth", {27'd0, bus.depth}, 32'd16);
        chk("overflow", {31'd0, bus.overflow}, 32'd1);
        for (int i = 16; i >= 1; i--) ret(32'h1000 + 4 * i, 0, 2'd0, 32'd0);
        chk("drained_depth", {27'd0, bus.depth}, 32'd0);
        ret(32'h1000, 1, 2'd2, 32'd0);
        chk("overflow_sticky", {31'd0, bus.overflow}, 32'd1);
        dec(T_JUMP, 6'd0, 6'd0, 6'd1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        bus.link_valid = 1'b1;
        bus.link_data = 32'h300;
        cyc();
        bus.link_valid = 1'b0;
        chk("rst_mid_depth", {27'd0, bus.depth}, 32'd0);
        chk("rst_mid_overflow", {31'd0, bus.overflow}, 32'd0);
        ret(32'h300, 1, 2'd2, 32'd0);
        call(32'h400);
`ifdef FWRISC_SHADOW_STACK_TIMEOUT_EN
        dec(T_JUMP, 6'd0, 6'd1, 6'd0);
        expq.push_back({2'd3, 32'd0, 32'd0});
        begin
            bit seen = 0;
            for (int i = 0; i < 40 && !seen; i++) begin
                cyc();
                seen = bus.err_valid;
            end
            chk("timeout_seen", {31'd0, seen}, 32'd1);
        end
        cyc();
        chk("timeout_depth", {27'd0, bus.depth}, 32'd1);
        ret(32'h400, 0, 2'd0, 32'd0);
`else
        dec(T_JUMP, 6'd0, 6'd1, 6'd0);
        repeat (30) cyc();
        expq.push_back({2'd0, 32'h400, 32'h404});
        bus.jump_valid = 1'b1;
        bus.jump_target = 32'h404;
        cyc();
        bus.jump_valid = 1'b0;
        cyc();
`endif
        chk("final_depth", {27'd0, bus.depth}, 32'd0);
        repeat (3) cyc();
        chk("queue_empty", expq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fwrisc_shadow_stack_checker.md
Name: fwrisc_shadow_stack_checker

Overview:
- Return-side companion to the callstack stomping checker: keeps a shadow stack of return addresses pushed on calls, checks them on returns and on link-register reloads.
- Flags when a return target, or a link value reloaded from the stack, differs from the value recorded at the matching call.
- Sits beside fwrisc decode/writeback as a non-intrusive monitor; drives only error/status outputs.

Parameters:
DEPTH, 16, shadow stack entries; power of 2, >= 2
DEPTH_W, $clog2(DEPTH), index width (derived; not overridden)

Ports:
clock  input  1  clock
reset  input  1  synchronous, active-high reset
decode_valid  input  1  instruction decoded this cycle
op_type  input  5  decoded op type (OP_TYPE_* encoding)
op  input  6  decoded op (OP_* encoding)
rs1  input  6  source register 1 address
rd  input  6  destination register address
link_valid  input  1  link-register writeback strobe for current jump
link_data  input  32  value written to link register (pc+4)
jump_valid  input  1  jump target resolved strobe
jump_target  input  32  resolved jump target
ld_valid  input  1  load data return strobe
ld_data  input  32  loaded data
err_valid  output  1  one-cycle error pulse
err_kind  output  2  0=RET_MISMATCH 1=LOAD_MISMATCH 2=UNDERFLOW 3=TIMEOUT
err_exp  output  32  expected value (shadow top; 0 on underflow)
err_act  output  32  actual value observed
depth  output  DEPTH_W+1  valid entries, 0..DEPTH
overflow  output  1  sticky: a push occurred while full

Behaviour:
- Reset (reset wins over all inputs, including mid-wait): state=IDLE, depth=0, top pointer=0, err_valid=0, err_kind=0, err_exp=0, err_act=0, overflow=0, timeout counter=0.
- Link register = x1 or x5. States: IDLE, CALL_WAIT, RET_WAIT, LOAD_WAIT.
- IDLE, decode_valid, op_type==OP_TYPE_JUMP:
  - rd is link -> CALL_WAIT (includes coroutine rd=x1/rs1=x5 or reverse: treated as call, no check).
  - rd==0 and rs1 is link -> RET_WAIT.
  - otherwise stay IDLE.
- IDLE, decode_valid, op_type==OP_TYPE_LDST, op==OP_LW, rd is link -> LOAD_WAIT.
- decode_valid outside IDLE ignored. link_valid/jump_valid/ld_valid ignored in any state other than the one waiting for them.
- CALL_WAIT + link_valid: write link_data at top pointer, pointer+1 mod DEPTH (wrap), depth=min(depth+1,DEPTH). If depth was DEPTH: oldest entry overwritten, overflow<=1. -> IDLE.
- RET_WAIT + jump_valid:
  - depth==0: error UNDERFLOW, exp=0, act=jump_target.
  - else: pop (pointer-1 mod DEPTH, depth-1); if jump_target != popped entry: error RET_MISMATCH, exp=entry, act=jump_target.
  - -> IDLE.
- LOAD_WAIT + ld_valid: depth!=0 and ld_data != top entry -> error LOAD_MISMATCH, exp=top, act=ld_data. No pop; depth==0 -> no check. -> IDLE.
- Error reporting: err_valid pulses exactly one cycle, the cycle after the completing strobe. err_kind/err_exp/err_act update with the pulse and hold until the next error.
- Comparisons full 32-bit equality. depth never exceeds DEPTH or goes below 0.

Optional Feature:
FWRISC_SHADOW_STACK_TIMEOUT_EN
- Defined: 4-bit counter clears on entering any WAIT state, increments each cycle in a WAIT state. On reaching 15 with no expected strobe: err TIMEOUT (exp=0, act=0), stack unchanged, -> IDLE. A strobe in the same cycle wins over the timeout.
- Undefined: WAIT states wait indefinitely; err_kind 3 never produced; no counter logic.

Test Plan:
- Call via JAL rd=1 with link_data=0x104, then JALR rd=0 rs1=1 with jump_target=0x104 -> depth 0->1->0, no err_valid.
- Same call, return with jump_target=0x108 -> err_valid one cycle, kind=0, exp=0x104, act=0x108, depth=0.
- Return with empty stack, target=0x200 -> kind=2, exp=0, act=0x200, depth stays 0.
- Push 0x100, then LW rd=1 returning 0x100, then LW rd=1 returning 0xDEAD -> no error first; second gives kind=1, exp=0x100, act=0xDEAD; depth stays 1.
- DEPTH+1 calls (0x1000+4*i), then DEPTH+1 returns in reverse order -> overflow=1, depth saturates at 16; first 16 returns match; 17th gives UNDERFLOW.
- Assert reset during CALL_WAIT, then raise link_valid -> no push, depth=0, state IDLE. With TIMEOUT_EN: RET_WAIT with no jump_valid for 15 cycles -> kind=3 pulse, depth unchanged.
